// File: rtl/cmd_pkg.sv
// Shared types and constants for the flight-controller command sequencer.
package cmd_pkg;

   typedef enum logic [7:0] {
      OP_SET_PTCH  = 8'h02,
      OP_SET_ROLL  = 8'h03,
      OP_SET_YAW   = 8'h04,
      OP_SET_THRST = 8'h05,
      OP_CALIBRATE = 8'h06,
      OP_EMER_LAND = 8'h07,
      OP_MTRS_OFF  = 8'h08
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE,
      CAL_WAIT,
      RESP,
      RESP_WAIT
   } state_e;

   localparam logic [7:0] ACK_DEF     = 8'hA5;
   localparam logic [7:0] NACK_DEF    = 8'hEE;
   localparam int         CAL_TMO_DEF = 1_000_000;

endpackage

// File: rtl/cmd_tmo_cnt.sv
// Clearable up-counter that stops at TMO-1 and flags the terminal count.
module cmd_tmo_cnt #(
   parameter int TMO = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int         W      = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [W-1:0] TC_VAL = W'(TMO - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !tc_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cmd_dispatch.sv
// Executes completed UART commands, updates flight setpoints, and returns one ACK/NACK byte.
module cmd_dispatch
   import cmd_pkg::*;
#(
   parameter int         CAL_TMO = CAL_TMO_DEF,
   parameter logic [7:0] ACK     = ACK_DEF,
   parameter logic [7:0] NACK    = NACK_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_rdy,
   input  logic [7:0]         cmd,
   input  logic [15:0]        data,
   output logic               clr_cmd_rdy,
   output logic               send_resp,
   output logic [7:0]         resp,
   input  logic               resp_sent,
   output logic signed [15:0] ptch,
   output logic signed [15:0] roll,
   output logic signed [15:0] yaw,
   output logic [8:0]         thrst,
   output logic               strt_cal,
   input  logic               cal_done,
   output logic               motors_off,
   output logic               busy
);

   state_e             state_q;
   logic               send_resp_q, strt_cal_q, motors_off_q;
   logic [7:0]         resp_q;
   logic signed [15:0] ptch_q, roll_q, yaw_q;
   logic [8:0]         thrst_q;
   logic               accept, tmo_tc;

   // Accept only in IDLE; a pending command during busy stays latched in the wrapper.
   assign accept      = (state_q == IDLE) && cmd_rdy && !rst;
   assign clr_cmd_rdy = accept;
   assign busy        = (state_q != IDLE);

   cmd_tmo_cnt #(.TMO(CAL_TMO)) u_cal_tmo (
      .clk   (clk),
      .rst   (rst),
      .clr_i (accept && (cmd == OP_CALIBRATE)),
      .en_i  (state_q == CAL_WAIT),
      .tc_o  (tmo_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         send_resp_q  <= 1'b0;
         strt_cal_q   <= 1'b0;
         motors_off_q <= 1'b1;
         resp_q       <= 8'h00;
         ptch_q       <= '0;
         roll_q       <= '0;
         yaw_q        <= '0;
         thrst_q      <= '0;
      end else begin
         send_resp_q <= 1'b0;
         strt_cal_q  <= 1'b0;
         case (state_q)
            IDLE: if (cmd_rdy) begin
               state_q <= RESP;
               resp_q  <= ACK;
               case (cmd)
                  OP_SET_PTCH:  ptch_q <= data;
                  OP_SET_ROLL:  roll_q <= data;
                  OP_SET_YAW:   yaw_q  <= data;
                  OP_SET_THRST: begin
                     thrst_q      <= data[8:0];
                     motors_off_q <= 1'b0;
                  end
                  OP_CALIBRATE: begin
                     motors_off_q <= 1'b0;
                     strt_cal_q   <= 1'b1;
                     state_q      <= CAL_WAIT;
                  end
                  OP_EMER_LAND: begin
                     ptch_q  <= '0;
                     roll_q  <= '0;
                     yaw_q   <= '0;
                     thrst_q <= '0;
                  end
                  OP_MTRS_OFF:  motors_off_q <= 1'b1;
                  default:      resp_q <= NACK;
               endcase
            end
            // cal_done is checked first so it wins a tie with the timeout.
            CAL_WAIT: begin
               if (cal_done) begin
                  state_q <= RESP;
                  resp_q  <= ACK;
               end else if (tmo_tc) begin
                  state_q <= RESP;
                  resp_q  <= NACK;
               end
            end
            RESP: begin
               send_resp_q <= 1'b1;
               state_q     <= RESP_WAIT;
            end
            RESP_WAIT: if (resp_sent) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign send_resp  = send_resp_q;
   assign strt_cal   = strt_cal_q;
   assign motors_off = motors_off_q;
   assign resp       = resp_q;
   assign ptch       = ptch_q;
   assign roll       = roll_q;
   assign yaw        = yaw_q;
   assign thrst      = thrst_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with a short calibration timeout.
module tb_cmd_dispatch;

   logic        clk = 1'b0;
   logic        rst, cmd_rdy, resp_sent, cal_done;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        clr_cmd_rdy, send_resp, strt_cal, motors_off, busy;
   logic [7:0]  resp;
   logic signed [15:0] ptch, roll, yaw;
   logic [8:0]  thrst;

   int vecs = 0;
   int errs = 0;

   cmd_dispatch #(.CAL_TMO(100)) dut (
      .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
      .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
      .resp_sent(resp_sent), .ptch(ptch), .roll(roll), .yaw(yaw),
      .thrst(thrst), .strt_cal(strt_cal), .cal_done(cal_done),
      .motors_off(motors_off), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   // From the negedge of a cycle (index start) counts cycles until send_resp is seen,
   // optionally pulsing cal_done at index cd_at, then completes the handshake.
   task automatic wait_resp(input int start, input int cd_at, output int lat, output logic [7:0] r);
      lat = start;
      while (!send_resp && lat < 300) begin
         tick;
         lat++;
         cal_done = (lat == cd_at);
         @(negedge clk);
      end
      cal_done = 1'b0;
      if (!send_resp) lat = -1;
      r = resp;
      tick;
      resp_sent = 1'b1;
      tick;
      resp_sent = 1'b0;
   endtask

   task automatic run_cmd(input logic [7:0] op, input logic [15:0] d,
                          output logic clr, output logic [7:0] r, output int lat);
      tick;
      cmd_rdy = 1'b1; cmd = op; data = d;
      @(negedge clk);
      clr = clr_cmd_rdy;
      tick;
      cmd_rdy = 1'b0;
      @(negedge clk);
      wait_resp(1, -1, lat, r);
   endtask

   task automatic kick_cal;
      tick;
      cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0000;
      tick;
      cmd_rdy = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_rdy = 1'b0; resp_sent = 1'b0; cal_done = 1'b0;
      cmd = 8'h00; data = 16'h0000;
      repeat (3) tick;
      rst = 1'b0;
      @(negedge clk);
      vecs++;
      if ({ptch, roll, yaw, thrst} !== 57'd0) begin
         errs++; $display("FAIL reset_setpoints: got %h/%h/%h/%h want 0", ptch, roll, yaw, thrst);
      end
      vecs++;
      if ({motors_off, send_resp, strt_cal, clr_cmd_rdy, busy, resp} !== {5'b10000, 8'h00}) begin
         errs++; $display("FAIL reset_ctrl: got mo=%b sr=%b sc=%b clr=%b busy=%b resp=%h want mo=1 others 0",
                          motors_off, send_resp, strt_cal, clr_cmd_rdy, busy, resp);
      end
   endtask

   task automatic test_set_ptch;
      tick;
      cmd_rdy = 1'b1; cmd = 8'h02; data = 16'hFF80;
      @(negedge clk);
      vecs++;
      if (clr_cmd_rdy !== 1'b1) begin errs++; $display("FAIL ptch_clr_n: got %b want 1", clr_cmd_rdy); end
      tick;
      cmd_rdy = 1'b0;
      @(negedge clk);
      vecs++;
      if (ptch !== 16'hFF80 || send_resp !== 1'b0) begin
         errs++; $display("FAIL ptch_n1: got ptch=%h sr=%b want ptch=ff80 sr=0", ptch, send_resp);
      end
      tick;
      @(negedge clk);
      vecs++;
      if (send_resp !== 1'b1 || resp !== 8'hA5) begin
         errs++; $display("FAIL ptch_n2: got sr=%b resp=%h want sr=1 resp=a5", send_resp, resp);
      end
      tick;
      @(negedge clk);
      vecs++;
      if (send_resp !== 1'b0 || resp !== 8'hA5 || busy !== 1'b1) begin
         errs++; $display("FAIL ptch_n3: got sr=%b resp=%h busy=%b want 0/a5/1", send_resp, resp, busy);
      end
      resp_sent = 1'b1;
      tick;
      resp_sent = 1'b0;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0) begin errs++; $display("FAIL ptch_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_set_thrst;
      logic c; logic [7:0] r; int lat;
      vecs++;
      if (motors_off !== 1'b1) begin errs++; $display("FAIL thrst_pre: got mo=%b want 1", motors_off); end
      run_cmd(8'h05, 16'hFFFF, c, r, lat);
      vecs++;
      if (thrst !== 9'h1FF || motors_off !== 1'b0) begin
         errs++; $display("FAIL thrst_val: got thrst=%h mo=%b want 1ff/0", thrst, motors_off);
      end
      vecs++;
      if (c !== 1'b1 || r !== 8'hA5 || lat !== 2) begin
         errs++; $display("FAIL thrst_resp: got clr=%b resp=%h lat=%0d want 1/a5/2", c, r, lat);
      end
   endtask

   task automatic test_mtrs_off;
      logic c; logic [7:0] r; int lat;
      run_cmd(8'h08, 16'h0000, c, r, lat);
      vecs++;
      if (motors_off !== 1'b1 || r !== 8'hA5 || thrst !== 9'h1FF) begin
         errs++; $display("FAIL mtrs_off: got mo=%b resp=%h thrst=%h want 1/a5/1ff", motors_off, r, thrst);
      end
   endtask

   task automatic test_cal_ack;
      logic [7:0] r; int lat;
      kick_cal;
      vecs++;
      if (strt_cal !== 1'b1 || motors_off !== 1'b0 || busy !== 1'b1) begin
         errs++; $display("FAIL cal_start: got sc=%b mo=%b busy=%b want 1/0/1", strt_cal, motors_off, busy);
      end
      tick;
      @(negedge clk);
      vecs++;
      if (strt_cal !== 1'b0) begin errs++; $display("FAIL cal_strt_pulse: got sc=%b want 0", strt_cal); end
      wait_resp(1, 50, lat, r);
      vecs++;
      if (lat !== 52 || r !== 8'hA5) begin
         errs++; $display("FAIL cal_ack: got lat=%0d resp=%h want 52/a5", lat, r);
      end
   endtask

   task automatic test_cal_tmo;
      logic [7:0] r; int lat;
      kick_cal;
      wait_resp(0, -1, lat, r);
      vecs++;
      if (lat !== 101 || r !== 8'hEE) begin
         errs++; $display("FAIL cal_tmo: got lat=%0d resp=%h want 101/ee", lat, r);
      end
   endtask

   task automatic test_cal_terminal;
      logic [7:0] r; int lat;
      kick_cal;
      wait_resp(0, 99, lat, r);
      vecs++;
      if (lat !== 101 || r !== 8'hA5) begin
         errs++; $display("FAIL cal_terminal: got lat=%0d resp=%h want 101/a5", lat, r);
      end
   endtask

   task automatic test_unknown;
      logic c; logic [7:0] r; int lat;
      run_cmd(8'h03, 16'h1234, c, r, lat);
      run_cmd(8'h04, 16'h8001, c, r, lat);
      run_cmd(8'h3C, 16'h5555, c, r, lat);
      vecs++;
      if (r !== 8'hEE || lat !== 2 || c !== 1'b1) begin
         errs++; $display("FAIL unk_resp: got resp=%h lat=%0d clr=%b want ee/2/1", r, lat, c);
      end
      vecs++;
      if (ptch !== 16'hFF80 || roll !== 16'h1234 || yaw !== 16'h8001 || thrst !== 9'h1FF) begin
         errs++; $display("FAIL unk_hold: got %h/%h/%h/%h want ff80/1234/8001/1ff", ptch, roll, yaw, thrst);
      end
   endtask

   task automatic test_emer_land;
      logic c; logic [7:0] r; int lat;
      run_cmd(8'h07, 16'hABCD, c, r, lat);
      vecs++;
      if ({ptch, roll, yaw, thrst} !== 57'd0 || r !== 8'hA5) begin
         errs++; $display("FAIL emer_land: got %h/%h/%h/%h resp=%h want zeros/a5", ptch, roll, yaw, thrst, r);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] r; int lat;
      tick;
      cmd_rdy = 1'b1; cmd = 8'h03; data = 16'h0055;
      @(negedge clk);
      vecs++;
      if (clr_cmd_rdy !== 1'b1) begin errs++; $display("FAIL b2b_clr_n: got %b want 1", clr_cmd_rdy); end
      tick;
      cmd = 8'h04; data = 16'h0AAA;
      @(negedge clk);
      vecs++;
      if (clr_cmd_rdy !== 1'b0) begin errs++; $display("FAIL b2b_clr_n1: got %b want 0", clr_cmd_rdy); end
      tick;
      @(negedge clk);
      vecs++;
      if (clr_cmd_rdy !== 1'b0 || send_resp !== 1'b1) begin
         errs++; $display("FAIL b2b_n2: got clr=%b sr=%b want 0/1", clr_cmd_rdy, send_resp);
      end
      tick;
      resp_sent = 1'b1;
      @(negedge clk);
      vecs++;
      if (clr_cmd_rdy !== 1'b0) begin errs++; $display("FAIL b2b_clr_sent: got %b want 0", clr_cmd_rdy); end
      tick;
      resp_sent = 1'b0;
      @(negedge clk);
      vecs++;
      if (clr_cmd_rdy !== 1'b1) begin errs++; $display("FAIL b2b_clr_after: got %b want 1", clr_cmd_rdy); end
      tick;
      cmd_rdy = 1'b0;
      @(negedge clk);
      vecs++;
      if (yaw !== 16'h0AAA || roll !== 16'h0055) begin
         errs++; $display("FAIL b2b_vals: got yaw=%h roll=%h want 0aaa/0055", yaw, roll);
      end
      wait_resp(1, -1, lat, r);
      vecs++;
      if (lat !== 2 || r !== 8'hA5) begin
         errs++; $display("FAIL b2b_resp: got lat=%0d resp=%h want 2/a5", lat, r);
      end
   endtask

   task automatic test_reset_mid_cal;
      logic c; logic [7:0] r; int lat; logic seen;
      run_cmd(8'h02, 16'h0100, c, r, lat);
      kick_cal;
      repeat (10) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      @(negedge clk);
      vecs++;
      if ({ptch, roll, yaw, thrst} !== 57'd0) begin
         errs++; $display("FAIL rstcal_setpoints: got %h/%h/%h/%h want 0", ptch, roll, yaw, thrst);
      end
      vecs++;
      if ({motors_off, send_resp, strt_cal, clr_cmd_rdy, busy, resp} !== {5'b10000, 8'h00}) begin
         errs++; $display("FAIL rstcal_ctrl: got mo=%b sr=%b sc=%b clr=%b busy=%b resp=%h want mo=1 others 0",
                          motors_off, send_resp, strt_cal, clr_cmd_rdy, busy, resp);
      end
      seen = 1'b0;
      for (int k = 0; k < 120; k++) begin
         tick;
         cal_done = (k == 5);
         @(negedge clk);
         if (send_resp || busy) seen = 1'b1;
      end
      cal_done = 1'b0;
      vecs++;
      if (seen !== 1'b0) begin errs++; $display("FAIL rstcal_quiet: got activity=%b want 0", seen); end
   endtask

   initial begin
      test_reset;
      test_set_ptch;
      test_set_thrst;
      test_mtrs_off;
      test_cal_ack;
      test_cal_tmo;
      test_cal_terminal;
      test_unknown;
      test_emer_land;
      test_back_to_back;
      test_reset_mid_cal;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/cmd_dispatch.md
# cmd_dispatch

Command sequencer sitting directly behind the UART command wrapper in the quadcopter flight controller. It consumes each completed 3-byte command (opcode plus 16-bit data), clears the wrapper's ready flag, and updates the flight setpoint registers or launches sensor calibration. It then returns exactly one response byte (ACK/NACK) through the wrapper's transmitter before accepting the next command.

## Interface
- CAL_TMO, 1_000_000: cycles allowed for calibration before NACK
- ACK, 8'hA5: positive response byte
- NACK, 8'hEE: negative response byte
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_rdy  in  1  wrapper holds a complete command
- cmd  in  8  opcode from wrapper
- data  in  16  payload from wrapper
- clr_cmd_rdy  out  1  one-cycle clear to wrapper
- send_resp  out  1  one-cycle transmit strobe to wrapper
- resp  out  8  response byte, stable from send_resp until resp_sent
- resp_sent  in  1  wrapper transmit complete (pulse)
- ptch, roll, yaw  out  16  signed setpoints
- thrst  out  9  unsigned thrust setpoint
- strt_cal  out  1  one-cycle calibration start
- cal_done  in  1  calibration complete (pulse)
- motors_off  out  1  motor kill
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes: 0x02 SET_PTCH, 0x03 SET_ROLL, 0x04 SET_YAW, 0x05 SET_THRST, 0x06 CALIBRATE, 0x07 EMER_LAND, 0x08 MTRS_OFF. Any other value is unknown.
- States: IDLE, CAL_WAIT, RESP, RESP_WAIT.
- IDLE with cmd_rdy=1: clr_cmd_rdy is high in the same cycle (combinational). The command executes at that edge.
  - SET_PTCH/ROLL/YAW: register loads data[15:0]. Next state RESP, resp=ACK.
  - SET_THRST: thrst loads data[8:0], upper bits are discarded. motors_off clears. Next state RESP, resp=ACK.
  - CALIBRATE: motors_off clears, timer clears. Next state CAL_WAIT.
  - EMER_LAND: ptch, roll, yaw and thrst all go to 0. Next state RESP, resp=ACK.
  - MTRS_OFF: motors_off sets. Next state RESP, resp=ACK.
  - Unknown opcode: no register change. Next state RESP, resp=NACK.
- CAL_WAIT: timer increments every cycle.
  - cal_done=1 → RESP, resp=ACK.
  - Timer reaches CAL_TMO-1 → RESP, resp=NACK.
  - cal_done wins if both occur in the same cycle.
- RESP: send_resp high for exactly one cycle. Next state RESP_WAIT.
- RESP_WAIT: on resp_sent → IDLE.
- cmd_rdy while busy: ignored and not cleared. The wrapper keeps it pending, and it is serviced on the first IDLE cycle.
- cal_done outside CAL_WAIT and resp_sent outside RESP_WAIT: ignored.

## Timing
- Reset values: ptch/roll/yaw/thrst=0, motors_off=1, resp=8'h00, send_resp=0, strt_cal=0, clr_cmd_rdy=0, busy=0, state IDLE.
- Reset asserted mid-operation returns every output to its reset value at the next edge. An in-flight calibration or response is abandoned with no response sent.
- cmd_rdy sampled in IDLE at cycle N:
  - clr_cmd_rdy high in cycle N.
  - Setpoint and motors_off updates are visible in cycle N+1.
  - For a non-calibrate command, send_resp is high in cycle N+2.
- CALIBRATE: strt_cal is high in cycle N+1 only.
  - cal_done at cycle M → send_resp in M+2.
  - With no cal_done, NACK send_resp occurs CAL_TMO+1 cycles after strt_cal.
- resp is registered and held unchanged from the state entry that sets it through RESP_WAIT.
- Throughput: one command per response round trip. The earliest next clr_cmd_rdy is the cycle after resp_sent.

## Structure
- Package cmd_pkg: opcode enum, ACK/NACK defaults, state enum type.
- Sub-module cmd_tmo_cnt: clearable saturating counter, width $clog2(CAL_TMO), with a terminal-count flag. Reused later for a comm-loss watchdog.
- Everything else lives in cmd_dispatch: FSM, setpoint registers, response register.

## Test plan
- Reset, then cmd=0x02 data=16'hFF80 → clr_cmd_rdy in cycle N, ptch=16'hFF80 in N+1, send_resp in N+2 with resp=8'hA5.
- cmd=0x05 data=16'hFFFF → thrst=9'h1FF, motors_off 1→0, ACK.
- cmd=0x06, cal_done pulsed 50 cycles after strt_cal → ACK. Repeat with no cal_done and CAL_TMO=100 → NACK exactly 101 cycles after strt_cal. Also pulse cal_done on the terminal cycle → ACK.
- cmd=0x3C → NACK, and all setpoints unchanged. Then cmd=0x07 → all setpoints 0, ACK.
- Hold cmd_rdy high during RESP_WAIT → no clr_cmd_rdy until the cycle after resp_sent, then that command executes.
- Assert rst during CAL_WAIT → next cycle all outputs at reset values, no send_resp, later cal_done ignored.
